// File: rtl/eth_reset_seq_pkg.sv
// Shared types and widths for the Ethernet reset sequencer.
package eth_rst_pkg;

  localparam int LOSS_CNT_W    = 8;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    PHY_RST     = 3'd2,
    PHY_SETTLE  = 3'd3,
    RUN         = 3'd4
  } state_t;

endpackage

// File: rtl/eth_reset_seq_if.sv
// Signal bundle between the reset sequencer (master) and the PLL/PHY/core side (slave).
interface eth_reset_seq_if;
  import eth_rst_pkg::*;

  logic                  pll_lock;
  logic                  phy_rst_n;
  logic                  core_rst;
  logic                  ready;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    input  pll_lock,
    output phy_rst_n, core_rst, ready, lock_loss_cnt
  );

  modport slave (
    output pll_lock,
    input  phy_rst_n, core_rst, ready, lock_loss_cnt
  );

endinterface

// File: rtl/eth_reset_seq_sync_2ff.sv
// Generic two-flop synchroniser with synchronous clear.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eth_reset_seq.sv
// Reset sequencer: PLL lock -> timed PHY reset -> settle -> core release.
// Define ETH_RST_LOCK_LOSS_CNT_EN to enable the saturating lock-loss counter.
module eth_reset_seq
  import eth_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PHY_RST_CYCLES     = 2500,
  parameter int PHY_SETTLE_CYCLES  = 5000,
  parameter int CNT_W              = DEFAULT_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  eth_reset_seq_if.master bus
);

  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_LOAD    = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(PHY_SETTLE_CYCLES - 1);

  state_t                state, next_state;
  logic [CNT_W-1:0]      cnt, next_cnt;
  logic                  lock_s;
  logic                  phy_rst_n_q, core_rst_q, ready_q;
  logic [LOSS_CNT_W-1:0] loss_cnt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .clr (rst),
    .d   (bus.pll_lock),
    .q   (lock_s)
  );

  // Loss of lock outranks any count expiry once the PHY sequence has begun.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          next_state = LOCK_STABLE;
          next_cnt   = LOCK_LOAD;
        end
      end
      LOCK_STABLE: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
        end else if (cnt == '0) begin
          next_state = PHY_RST;
          next_cnt   = PHY_LOAD;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      PHY_RST: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
        end else if (cnt == '0) begin
          next_state = PHY_SETTLE;
          next_cnt   = SETTLE_LOAD;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      PHY_SETTLE: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
        end else if (cnt == '0) begin
          next_state = RUN;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) next_state = WAIT_LOCK;
      end
      default: next_state = WAIT_LOCK;
    endcase
  end

  // Outputs decode next_state so they switch on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      phy_rst_n_q <= 1'b0;
      core_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      phy_rst_n_q <= (next_state == PHY_SETTLE) || (next_state == RUN);
      core_rst_q  <= (next_state != RUN);
      ready_q     <= (next_state == RUN);
    end
  end

`ifdef ETH_RST_LOCK_LOSS_CNT_EN
  logic loss_event;

  assign loss_event = !lock_s &&
                      ((state == PHY_RST) || (state == PHY_SETTLE) || (state == RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (loss_event && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
    end
  end
`else
  assign loss_cnt = '0;
`endif

  assign bus.phy_rst_n     = phy_rst_n_q;
  assign bus.core_rst      = core_rst_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_eth_reset_seq.sv
// Scoreboard bench for eth_reset_seq with L=4, P=6, S=3; checks every edge.
module tb_eth_reset_seq;
  import eth_rst_pkg::*;

  localparam int L = 4;
  localparam int P = 6;
  localparam int S = 3;
  localparam int PHY_EDGE = 3 + L + P;
  localparam int RUN_EDGE = 3 + L + P + S;

  typedef struct {
    string       tag;
    logic [10:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  eth_reset_seq_if bus ();

  eth_reset_seq #(
    .LOCK_STABLE_CYCLES (L),
    .PHY_RST_CYCLES     (P),
    .PHY_SETTLE_CYCLES  (S),
    .CNT_W              (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] exp_loss(input int n);
`ifdef ETH_RST_LOCK_LOSS_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0 + 8'(n - n);
`endif
  endfunction

  // {phy_rst_n, core_rst, ready, lock_loss_cnt}; k=1 is the first edge sampling lock high
  function automatic logic [10:0] nominal_exp(input int k, input logic [7:0] loss);
    logic phy, core, rdy;
    phy  = (k >= PHY_EDGE);
    core = (k < RUN_EDGE);
    rdy  = (k >= RUN_EDGE);
    return {phy, core, rdy, loss};
  endfunction

  function automatic logic [10:0] reset_exp();
    return {1'b0, 1'b1, 1'b0, 8'd0};
  endfunction

  task automatic checkOutput();
    exp_t        e;
    logic [10:0] obs;
    if (sb.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e   = sb.pop_front();
      obs = {bus.phy_rst_n, bus.core_rst, bus.ready, bus.lock_loss_cnt};
      compared++;
      assert (obs === e.val)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic lock_v,
                               input string tag, input logic [10:0] val);
    exp_t e;
    rst          = rst_v;
    bus.pll_lock = lock_v;
    e.tag        = tag;
    e.val        = val;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runNominal(input string tag, input int n, input logic [7:0] loss);
    for (int k = 1; k <= n; k++)
      applyStimulus(1'b0, 1'b1, $sformatf("%s_k%0d", tag, k), nominal_exp(k, loss));
  endtask

  // Three low edges: two still in RUN through the synchroniser, then reset outputs.
  task automatic dropLock(input string tag, input int loss_events);
    applyStimulus(1'b0, 1'b0, {tag, "_d1"}, nominal_exp(RUN_EDGE, exp_loss(loss_events - 1)));
    applyStimulus(1'b0, 1'b0, {tag, "_d2"}, nominal_exp(RUN_EDGE, exp_loss(loss_events - 1)));
    applyStimulus(1'b0, 1'b0, {tag, "_d3"}, {3'b010, exp_loss(loss_events)});
  endtask

  initial begin
    bus.pll_lock = 1'b0;

    // Test 1: nominal sequence with lock high throughout.
    applyStimulus(1'b1, 1'b1, "t1_rst_a", reset_exp());
    applyStimulus(1'b1, 1'b1, "t1_rst_b", reset_exp());
    runNominal("t1", 20, 8'd0);

    // Test 2: lock arrives 20 cycles after reset release.
    applyStimulus(1'b1, 1'b0, "t2_rst", reset_exp());
    for (int i = 1; i <= 20; i++)
      applyStimulus(1'b0, 1'b0, $sformatf("t2_nolock_%0d", i), reset_exp());
    runNominal("t2", 18, 8'd0);

    // Test 3: one-cycle glitch two edges into LOCK_STABLE restarts the count.
    applyStimulus(1'b1, 1'b1, "t3_rst", reset_exp());
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b0, 1'b1, $sformatf("t3_pre_%0d", k), nominal_exp(k, 8'd0));
    applyStimulus(1'b0, 1'b0, "t3_glitch", nominal_exp(5, 8'd0));
    runNominal("t3", 17, 8'd0);

    // Test 4: lock loss in RUN, then a full re-lock sequence.
    dropLock("t4", 1);
    runNominal("t4_relock", 17, exp_loss(1));

    // Test 5: rst during PHY_SETTLE clears everything, then nominal timing again.
    dropLock("t5", 2);
    runNominal("t5_pre", PHY_EDGE + 1, exp_loss(2));
    applyStimulus(1'b1, 1'b1, "t5_rst_settle", reset_exp());
    applyStimulus(1'b1, 1'b1, "t5_rst_hold", reset_exp());
    runNominal("t5_post", 18, 8'd0);

    // Test 6: 300 lock-loss events from RUN; counter saturates and holds.
    for (int i = 1; i <= 300; i++) begin
      dropLock($sformatf("t6_%0d", i), i);
      runNominal($sformatf("t6_%0d", i), RUN_EDGE, exp_loss(i));
    end
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, $sformatf("t6_hold_%0d", i), nominal_exp(RUN_EDGE, exp_loss(300)));

    if (sb.size() != 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
